// File: rtl/game_ctrl.sv
// game_ctrl: run/freeze/restart sequencer for the Dino game.
// Synchronizes the start button, sequences IDLE/RUN/DEAD/WAIT, keeps the
// session high score and a difficulty level tracked from the BCD score.
module game_ctrl #(
   parameter int LOCKOUT_TICKS = 30,
   parameter int MAX_LEVEL     = 7,
   parameter int LEVEL_W       = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               btn,
   input  logic               collision,
   input  logic               game_tick,
   input  logic [19:0]        score,
   output logic               game_start,
   output logic               game_frozen,
   output logic [19:0]        high_score,
   output logic               new_high,
   output logic [LEVEL_W-1:0] speed_level,
   output logic [1:0]         state
);

   // Handshake note: this block has no valid/ready pairs; game_start is a
   // single-cycle strobe and every other output is a level that is only
   // meaningful while it is held.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DEAD = 2'd2,
      WAIT = 2'd3
   } state_t;

   localparam logic [7:0]         LOCK_INIT = 8'(LOCKOUT_TICKS);
   localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(MAX_LEVEL);
   localparam logic [LEVEL_W-1:0] LEVEL_ONE = LEVEL_W'(1);

   state_t      st;
   logic        btn_s1;
   logic        btn_s2;
   logic        btn_s2_d;
   logic        press;
   logic [7:0]  lock_cnt;
   logic [3:0]  hund_ref;

   assign state = st;

   // Two-flop synchronizer plus registered rising-edge detect of the button.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_s1   <= 1'b0;
         btn_s2   <= 1'b0;
         btn_s2_d <= 1'b0;
         press    <= 1'b0;
      end else begin
         btn_s1   <= btn;
         btn_s2   <= btn_s1;
         btn_s2_d <= btn_s2;
         press    <= btn_s2 & ~btn_s2_d;
      end
   end

   // Game FSM with all outputs, high score and speed tracking registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st          <= IDLE;
         game_start  <= 1'b0;
         game_frozen <= 1'b1;
         high_score  <= 20'h0;
         new_high    <= 1'b0;
         speed_level <= '0;
         lock_cnt    <= 8'd0;
         hund_ref    <= 4'd0;
      end else begin
         game_start <= 1'b0;
         case (st)
            IDLE, WAIT: begin
               // A fresh press starts a run; the score counter clears on game_start.
               if (press) begin
                  st          <= RUN;
                  game_start  <= 1'b1;
                  game_frozen <= 1'b0;
                  new_high    <= 1'b0;
                  speed_level <= '0;
                  hund_ref    <= 4'd0;
               end
            end
            RUN: begin
               // Any change of the hundreds digit (including 9->0) bumps the level.
               if (score[11:8] != hund_ref) begin
                  hund_ref <= score[11:8];
                  if (speed_level < LEVEL_MAX) begin
                     speed_level <= speed_level + LEVEL_ONE;
                  end
               end
               // Collision has priority over press; press is a jump while running.
               if (collision) begin
                  st          <= DEAD;
                  game_frozen <= 1'b1;
                  lock_cnt    <= LOCK_INIT;
                  // Valid BCD orders the same as plain binary.
                  if (score > high_score) begin
                     high_score <= score;
                     new_high   <= 1'b1;
                  end else begin
                     new_high   <= 1'b0;
                  end
               end
            end
            DEAD: begin
               // Lockout counts frame ticks; the last tick moves straight to WAIT.
               if (game_tick) begin
                  if (lock_cnt <= 8'd1) begin
                     st       <= WAIT;
                     lock_cnt <= 8'd0;
                  end else begin
                     lock_cnt <= lock_cnt - 8'd1;
                  end
               end
            end
            default: begin
               st          <= IDLE;
               game_frozen <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with a small expected-value queue.
module tb_game_ctrl;

   logic        clk;
   logic        rst_n;
   logic        btn;
   logic        collision;
   logic        game_tick;
   logic [19:0] score;
   logic        game_start;
   logic        game_frozen;
   logic [19:0] high_score;
   logic        new_high;
   logic [2:0]  speed_level;
   logic [1:0]  state;

   int checks = 0;
   int errors = 0;
   int start_cnt = 0;
   logic [31:0] exp_q[$];

   game_ctrl #(.LOCKOUT_TICKS(3), .MAX_LEVEL(7), .LEVEL_W(3)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .btn(btn),
      .collision(collision),
      .game_tick(game_tick),
      .score(score),
      .game_start(game_start),
      .game_frozen(game_frozen),
      .high_score(high_score),
      .new_high(new_high),
      .speed_level(speed_level),
      .state(state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (game_start) start_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic pop_chk(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s observed=%h expected=<queue empty>", tag, obs);
      end else begin
         e = exp_q.pop_front();
         chk(tag, obs, e);
      end
   endtask

   // driver: raise btn, expect game_start exactly 4 cycles later, then release
   task automatic do_start(input string tag);
      int n;
      n = 0;
      btn = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!game_start && n < 10);
      chk({tag, "_latency"}, 32'(n), 32'd4);
      chk({tag, "_state"}, 32'(state), 32'd1);
      chk({tag, "_frozen"}, 32'(game_frozen), 32'd0);
      btn = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic do_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         game_tick = 1'b1;
         @(negedge clk);
         game_tick = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      int s0;
      int lvl;
      logic [3:0] ref_d;
      logic [19:0] sc;

      rst_n = 1'b0; btn = 1'b0; collision = 1'b0; game_tick = 1'b0; score = 20'h0;
      repeat (3) @(negedge clk);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_frozen", 32'(game_frozen), 32'd1);
      chk("rst_start", 32'(game_start), 32'd0);
      chk("rst_high", 32'(high_score), 32'd0);
      chk("rst_new_high", 32'(new_high), 32'd0);
      chk("rst_speed", 32'(speed_level), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // collision in IDLE is ignored
      collision = 1'b1;
      repeat (2) @(negedge clk);
      collision = 1'b0;
      chk("idle_coll_state", 32'(state), 32'd0);
      chk("idle_coll_frozen", 32'(game_frozen), 32'd1);

      // first run: start pulse width, then die at 123
      btn = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("start_early", 32'(game_start), 32'd0);
      end
      @(negedge clk);
      chk("start_pulse", 32'(game_start), 32'd1);
      chk("start_state", 32'(state), 32'd1);
      chk("start_frozen", 32'(game_frozen), 32'd0);
      @(negedge clk);
      chk("start_width", 32'(game_start), 32'd0);
      btn = 1'b0;
      repeat (4) @(negedge clk);

      score = 20'h00123;
      collision = 1'b1;
      push(32'h00123);
      push(32'd1);
      @(negedge clk);
      collision = 1'b0;
      chk("death1_state", 32'(state), 32'd2);
      chk("death1_frozen", 32'(game_frozen), 32'd1);
      @(negedge clk);
      pop_chk("death1_high", 32'(high_score));
      pop_chk("death1_new_high", 32'(new_high));

      // lockout: press before third tick is ignored
      s0 = start_cnt;
      do_ticks(2);
      btn = 1'b1;
      repeat (6) @(negedge clk);
      btn = 1'b0;
      chk("lockout_state", 32'(state), 32'd2);
      chk("lockout_nostart", 32'(start_cnt), 32'(s0));
      repeat (4) @(negedge clk);
      do_ticks(1);
      chk("lockout_wait", 32'(state), 32'd3);
      score = 20'h0;
      do_start("restart1");
      chk("restart1_new_high", 32'(new_high), 32'd0);

      // second run dies lower: high score keeps 123
      score = 20'h00099;
      @(negedge clk);
      collision = 1'b1;
      push(32'h00123);
      push(32'd0);
      @(negedge clk);
      collision = 1'b0;
      @(negedge clk);
      pop_chk("death2_high", 32'(high_score));
      pop_chk("death2_new_high", 32'(new_high));
      do_ticks(3);
      chk("wait2_state", 32'(state), 32'd3);
      score = 20'h0;
      do_start("restart2");

      // collision and press in the same RUN cycle
      s0 = start_cnt;
      btn = 1'b1;
      repeat (3) @(negedge clk);
      collision = 1'b1;
      @(negedge clk);
      collision = 1'b0;
      chk("simul_state", 32'(state), 32'd2);
      chk("simul_nostart", 32'(start_cnt), 32'(s0));
      btn = 1'b0;
      repeat (4) @(negedge clk);
      do_ticks(3);
      score = 20'h0;
      do_start("restart3");

      // speed sweep 0 -> 950 in steps of 50, then wrap to 1000
      lvl = 0;
      ref_d = 4'd0;
      for (int i = 0; i <= 20; i++) begin
         sc = (i == 20) ? 20'h01000 : 20'((i / 2) * 256 + ((i % 2) * 80));
         score = sc;
         if (sc[11:8] != ref_d) begin
            ref_d = sc[11:8];
            if (lvl < 7) lvl++;
         end
         push(32'(lvl));
         @(negedge clk);
         pop_chk($sformatf("speed_%0d", i), 32'(speed_level));
      end
      chk("speed_sat", 32'(speed_level), 32'd7);

      // die at 1000: new high, speed held through DEAD and WAIT
      collision = 1'b1;
      push(32'h01000);
      push(32'd1);
      @(negedge clk);
      collision = 1'b0;
      @(negedge clk);
      pop_chk("death3_high", 32'(high_score));
      pop_chk("death3_new_high", 32'(new_high));
      do_ticks(3);
      chk("wait3_speed", 32'(speed_level), 32'd7);
      score = 20'h0;
      do_start("restart4");
      chk("restart4_speed", 32'(speed_level), 32'd0);
      chk("restart4_new_high", 32'(new_high), 32'd0);

      // asynchronous reset between edges mid-run
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_state", 32'(state), 32'd0);
      chk("arst_frozen", 32'(game_frozen), 32'd1);
      chk("arst_high", 32'(high_score), 32'd0);
      chk("arst_speed", 32'(speed_level), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_state", 32'(state), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Top-level game sequencer for the Dino game. It decides when a run starts, freezes and restarts, and drives the `game_start` pulse and `game_frozen` level into the score counter. It also keeps the session high score and a difficulty level derived from the live BCD score. It sits between the input/collision logic and the score and obstacle datapaths, all in the single `clk` domain.

## Interface
- `LOCKOUT_TICKS`, default 30: game_ticks after death during which the button is ignored (1..255).
- `MAX_LEVEL`, default 7: saturation value of `speed_level`.
- `LEVEL_W`, default 3: width of `speed_level`; must hold `MAX_LEVEL`.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `btn`  in  1  jump/start button, raw level, asynchronous to `clk`.
- `collision`  in  1  level from the obstacle logic, synchronous to `clk`.
- `game_tick`  in  1  one-cycle pulse per 60 Hz frame.
- `score`  in  20  live score, 5 BCD digits, `[3:0]` = ones.
- `game_start`  out  1  one-cycle pulse that clears the score counter.
- `game_frozen`  out  1  high whenever the game is not running.
- `high_score`  out  20  best finished score, BCD.
- `new_high`  out  1  last run set a new high score.
- `speed_level`  out  `LEVEL_W`  difficulty level for the obstacle logic.
- `state`  out  2  encoded FSM state, for debug and display.

## Operation
- `btn` passes through a 2-flop synchronizer. `press` is the rising edge of the synchronized level, registered, so it lags raw `btn` by 3 cycles.
- FSM states and `state` encoding: IDLE=0, RUN=1, DEAD=2, WAIT=3.
  - IDLE: frozen. `press` → RUN and assert `game_start` for exactly that transition cycle.
  - RUN: not frozen.
    - `collision` → DEAD.
    - `press` is ignored (jump is handled elsewhere).
    - If `collision` and `press` occur in the same cycle, collision wins.
  - DEAD: frozen.
    - On entry, load the lockout counter with `LOCKOUT_TICKS`. It decrements on each `game_tick`.
    - When the counter reaches 0, go to WAIT.
    - `press` is ignored throughout DEAD.
  - WAIT: frozen. `press` → RUN with `game_start` pulse, same as from IDLE.
- `game_frozen` = 1 in IDLE, DEAD and WAIT; 0 in RUN. It is registered and aligned with `state`.
- High score update:
  - On the RUN→DEAD transition cycle, compare `score` against `high_score` as an unsigned 20-bit value (valid BCD orders the same as binary).
  - If strictly greater, load `high_score` with `score` and set `new_high`=1 in the next cycle; otherwise set `new_high`=0.
  - `new_high` holds until the next `game_start`, which clears it.
  - `high_score` is never cleared except by reset.
- Speed level:
  - `game_start` clears `speed_level` and captures the hundreds digit reference as 0.
  - In RUN, whenever `score[11:8]` differs from the captured digit, recapture it and increment `speed_level`, saturating at `MAX_LEVEL`.
  - Wrap of the hundreds digit from 9 to 0 counts as a change.
  - `speed_level` holds its value in DEAD and WAIT.
- `collision` is ignored outside RUN. `game_tick` only matters in DEAD.

## Timing
- Reset (asynchronous, takes effect immediately), values:
  - `state`=IDLE
  - `game_start`=0
  - `game_frozen`=1
  - `high_score`=0
  - `new_high`=0
  - `speed_level`=0
  - lockout counter=0
  - synchronizer flops=0
- Reset asserted mid-run aborts the run; `high_score` is lost.
- Raw `btn` rise to `game_start` high is 4 cycles. `game_frozen` falls in the same cycle `game_start` is high.
- `collision` high at edge N: `state`=DEAD and `game_frozen`=1 after edge N, `high_score`/`new_high` valid after edge N+1.
- DEAD lasts exactly `LOCKOUT_TICKS` `game_tick` pulses. The state is WAIT in the cycle after the final tick.
- A `press` in the same cycle DEAD→WAIT is taken is ignored; a new rising edge is needed.
- A `press` held high across a state change does not retrigger; only edges count.
- `speed_level` updates 1 cycle after `score[11:8]` changes.

## Test plan
- **Reset and start:** after reset, outputs are IDLE/frozen/0. Pulse `btn` → `game_start` high for exactly 1 cycle, 4 cycles after the rise; `game_frozen`=0; `state`=1.
- **Death and high score:** drive `score`=20'h00123 and assert `collision` → `state`=2, `high_score`=20'h00123, `new_high`=1. Next run dies at 20'h00099 → `high_score` stays 20'h00123, `new_high`=0.
- **Lockout:** after death with `LOCKOUT_TICKS`=3, press `btn` before the 3rd tick → no start, `state` stays 2. After 3 ticks `state`=3; press → `game_start`.
- **Simultaneous events:** `collision` and `press` in the same RUN cycle → DEAD, no `game_start`. `collision` while in IDLE → no state change.
- **Speed level:** sweep `score` 0→20'h00950 in RUN → `speed_level` steps 0..7 and saturates at 7. A new `game_start` → 0.
- **Async reset mid-run:** drop `rst_n` between edges → outputs reach reset values before the next edge; `high_score`=0.
